// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and defaults for the nibble serial transmitter.
package nibble_serial_tx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 4;
  localparam int unsigned PARITY_EN_DEF    = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [3:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module bit_timer
  import nibble_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter wraps at every bit boundary and is held at zero while idle.
  always_comb begin
    cnt_d  = cnt_q;
    last_o = en_i && (cnt_q == LAST_CNT);
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Nibble serial transmitter: start bit, 4 data bits LSB first, optional even parity, stop bit.
module nibble_serial_tx
  import nibble_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned PARITY_EN    = PARITY_EN_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LOAD,
  input  logic [3:0] DIN,
  output logic [3:0] Q,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  tx_state_t  state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       last_s;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i  (CLK),
    .rst_n_i(RST_N),
    .en_i   (state_q != IDLE),
    .last_o (last_s)
  );

  // Next state, and output flops fed from the next state so TX/BUSY/DONE line up with it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          state_d = START;
          hold_d  = DIN;
          idx_d   = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (last_s) begin
          state_d = DATA;
          idx_d   = 2'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (last_s) begin
          if (idx_q == 2'd3) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (last_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (last_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = hold_d[idx_d];
      PARITY:  tx_d = even_parity(hold_d);
      STOP:    tx_d = 1'b1;
      IDLE:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= 4'b0000;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = hold_q;
  assign TX   = tx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench: four transmitter configurations driven with directed and random traffic.
module tb_nibble_serial_tx;

  typedef struct {
    int         start;
    logic [3:0] d;
    bit         rst;
  } ev_t;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int fin_cnt  = 0;

  function automatic int cpb_of(input int g);
    case (g)
      0:       return 4;
      1:       return 4;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int par_of(input int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, inst, cyc, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int C = cpb_of(g);
    localparam int P = par_of(g);
    localparam int L = (6 + P) * C;

    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] din   = 4'h0;
    logic [3:0] q;
    logic       tx, busy, done;

    ev_t evq[$];
    int  busy_until = 0;

    nibble_serial_tx #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   (P)
    ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .LOAD (load),
      .DIN  (din),
      .Q    (q),
      .TX   (tx),
      .BUSY (busy),
      .DONE (done)
    );

    // Drive one cycle; the model decides whether the DUT is free to accept a LOAD.
    task automatic step(input bit r, input bit l, input logic [3:0] d);
      rst_n = ~r;
      load  = l;
      din   = d;
      if (r) begin
        evq.push_back('{cyc + 1, 4'h0, 1'b1});
        busy_until = cyc + 1;
      end else if (l && cyc >= busy_until) begin
        evq.push_back('{cyc + 1, d, 1'b0});
        busy_until = cyc + 1 + L;
      end
      @(posedge clk);
      #1;
    endtask

    initial begin : stim
      @(posedge clk);
      #1;
      step(1'b1, 1'b1, 4'hF);
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      // basic frame then a back-to-back LOAD in the DONE cycle
      step(1'b0, 1'b1, 4'b1010);
      while (cyc < busy_until) step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'b0011);
      while (cyc < busy_until + 2) step(1'b0, 1'b0, 4'h0);
      // LOAD while busy must be ignored
      step(1'b0, 1'b1, 4'b0001);
      repeat (9) step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'b1111);
      while (cyc < busy_until + 2) step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'b0111);
      while (cyc < busy_until + 1) step(1'b0, 1'b0, 4'h0);
      // reset during the data bits
      step(1'b0, 1'b1, 4'b1001);
      repeat (C + 1) step(1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h0);
      repeat (3) step(1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 300; i++) begin
        bit r, l;
        r = ($urandom_range(0, 60) == 0);
        l = ($urandom_range(0, 2) == 0);
        step(r, l, 4'($urandom));
      end
      while (cyc <= busy_until) step(1'b0, 1'b0, 4'h0);
      repeat (3) step(1'b0, 1'b0, 4'h0);
      @(negedge clk);
      chk("drain", g, (evq.size() == 0) ? 4'h1 : 4'h0, 4'h1);
      fin_cnt++;
    end

    initial begin : mon
      bit         in_f;
      int         k;
      int         done_at;
      logic [3:0] qexp;
      logic       bits [7];
      ev_t        e;
      in_f    = 1'b0;
      k       = 0;
      done_at = -1;
      qexp    = 4'h0;
      for (int i = 0; i < 7; i++) bits[i] = 1'b1;
      forever begin
        @(negedge clk);
        if (cyc >= 1) begin
          while (evq.size() > 0 && evq[0].start == cyc) begin
            e = evq.pop_front();
            if (e.rst) begin
              in_f    = 1'b0;
              done_at = -1;
              qexp    = 4'h0;
            end else begin
              in_f = 1'b1;
              k    = 0;
              qexp = e.d;
              bits[0] = 1'b0;
              for (int i = 0; i < 4; i++) bits[i + 1] = e.d[i];
              if (P != 0) begin
                bits[5] = e.d[0] ^ e.d[1] ^ e.d[2] ^ e.d[3];
                bits[6] = 1'b1;
              end else begin
                bits[5] = 1'b1;
              end
            end
          end
          chk("busy", g, {3'b000, busy}, {3'b000, in_f});
          chk("tx", g, {3'b000, tx}, in_f ? {3'b000, bits[k / C]} : 4'h1);
          chk("done", g, {3'b000, done}, {3'b000, (cyc == done_at)});
          chk("q", g, q, qexp);
          if (in_f) begin
            k++;
            if (k == L) begin
              in_f    = 1'b0;
              done_at = cyc + 1;
            end
          end
        end
      end
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (fin_cnt < NI && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (fin_cnt < NI) begin
      checks++;
      failures++;
      $display("FAIL timeout finished=%0d required=%0d", fin_cnt, NI);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
